// File: rtl/demux_merge_if.sv
// Handshake bundle between the 1-to-2 demux legs, the merge block and its consumer.
// master drives the channel words and out_ready; slave is the merge block.
interface demux_merge_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ch;
  logic             out_ready;

  modport master (
    output in0_valid, in0_data,
    output in1_valid, in1_data,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_ch
  );

  modport slave (
    input  in0_valid, in0_data,
    input  in1_valid, in1_data,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_ch
  );
endinterface

// File: rtl/demux_merge.sv
// Merges both demux legs through per-channel FIFOs and a registered output stage.
// Define MERGE_STRICT_PRIO_EN for fixed channel-0 priority instead of round-robin.
module demux_merge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_merge_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  logic [AW-1:0] wp0, rp0;
  logic [AW-1:0] wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;

  logic             ov_q;
  logic [WIDTH-1:0] od_q;
  logic             och_q;

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic load;
  logic gnt1;

  assign full0  = (cnt0 == CW'(DEPTH));
  assign full1  = (cnt1 == CW'(DEPTH));
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);

  // Ready comes from the registered count only: a full FIFO
  // refuses a word even when it is being drained this cycle.
  assign push0 = bus.in0_valid && !full0;
  assign push1 = bus.in1_valid && !full1;

  assign load = !ov_q || bus.out_ready;

`ifdef MERGE_STRICT_PRIO_EN
  always_comb begin
    gnt1 = 1'b0;
    unique case (1'b1)
      !empty0: gnt1 = 1'b0;
      default: gnt1 = !empty1;
    endcase
  end
`else
  logic last_grant;

  always_comb begin
    gnt1 = 1'b0;
    unique case (1'b1)
      (empty0 && !empty1):  gnt1 = 1'b1;
      (!empty0 && empty1):  gnt1 = 1'b0;
      (!empty0 && !empty1): gnt1 = !last_grant;
      default:              gnt1 = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (pop0 || pop1) begin
      last_grant <= gnt1;
    end
  end
`endif

  assign pop0 = load && !empty0 && !gnt1;
  assign pop1 = load && !empty1 && gnt1;

  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= bus.in0_data;
    if (push1) mem1[wp1] <= bus.in1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
    end else begin
      if (push0) wp0 <= wp0 + AW'(1);
      if (pop0)  rp0 <= rp0 + AW'(1);
      cnt0 <= cnt0 + CW'(push0) - CW'(pop0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push1) wp1 <= wp1 + AW'(1);
      if (pop1)  rp1 <= rp1 + AW'(1);
      cnt1 <= cnt1 + CW'(push1) - CW'(pop1);
    end
  end

  // Data and channel tag hold their last value when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
      och_q <= 1'b0;
    end else if (load) begin
      if (pop0 || pop1) begin
        ov_q  <= 1'b1;
        od_q  <= gnt1 ? mem1[rp1] : mem0[rp0];
        och_q <= gnt1;
      end else begin
        ov_q  <= 1'b0;
      end
    end
  end

  assign bus.in0_ready = !full0;
  assign bus.in1_ready = !full1;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_ch    = och_q;

endmodule
